// File: rtl/fb_rect_fill.sv
// -----------------------------------------------------------------------------
// fb_rect_fill
//
// Rectangle-fill engine for a linear framebuffer. It accepts one fill command
// (inclusive corners plus a 3-bit colour) and then streams one framebuffer
// write per clock, in raster order, until the rectangle is covered. A
// one-cycle DONE state follows every command, including empty or rejected
// ones. Then the engine returns to IDLE.
//
// Build option:
//   FB_RECT_CLIP_EN  When defined, x1/y1 are clamped to the screen edge and
//                    commands starting off-screen become empty. err never
//                    asserts in this build. When undefined, any coordinate
//                    that lies off-screen rejects the whole command with err.
//
// Parameters:
//   H_RES          framebuffer width in pixels
//   V_RES          framebuffer height in pixels
//
// Ports:
//   clk_write      single clock, rising edge
//   resetn         synchronous, active-low reset
//   cmd_valid      a fill command is presented
//   cmd_ready      engine is idle and takes the command on this edge
//   cmd_x0/cmd_y0  top-left corner, inclusive
//   cmd_x1/cmd_y1  bottom-right corner, inclusive
//   cmd_color      pixel value to write
//   write_enable   framebuffer write strobe
//   write_address  linear pixel address y*H_RES+x
//   data_out       pixel value (zero when not writing)
//   busy           command in progress (FILL or DONE)
//   done           one-cycle completion pulse
//   err            one-cycle pulse together with done when a command is rejected
// -----------------------------------------------------------------------------
module fb_rect_fill #(
  parameter int H_RES = 160,
  parameter int V_RES = 120
) (
  input  logic        clk_write,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_x0,
  input  logic [6:0]  cmd_y0,
  input  logic [7:0]  cmd_x1,
  input  logic [6:0]  cmd_y1,
  input  logic [2:0]  cmd_color,
  output logic        write_enable,
  output logic [14:0] write_address,
  output logic [2:0]  data_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int AW = 15;

  // Screen limits in widths that compare directly against the command
  // fields. The extra top bit keeps a limit of 256/128 representable.
  localparam logic [8:0]    X_LIM      = 9'(H_RES);
  localparam logic [7:0]    Y_LIM      = 8'(V_RES);
  localparam logic [AW-1:0] ROW_STRIDE = AW'(H_RES);
`ifdef FB_RECT_CLIP_EN
  localparam logic [7:0]    X_MAX      = 8'(H_RES - 1);
  localparam logic [6:0]    Y_MAX      = 7'(V_RES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_reg,   state_next;
  logic [7:0]      x_reg,       x_next;
  logic [7:0]      x0_reg,      x0_next;
  logic [7:0]      x1_reg,      x1_next;
  logic [6:0]      y_reg,       y_next;
  logic [6:0]      y1_reg,      y1_next;
  logic [AW-1:0]   addr_reg,    addr_next;
  logic [AW-1:0]   row_reg,     row_next;     // address of (x0, current row)
  logic [2:0]      color_reg,   color_next;
  logic            err_reg,     err_next;

  // ---------------------------------------------------------------------------
  // Command decode: effective bottom-right corner, reject and empty flags.
  // ---------------------------------------------------------------------------
  logic [7:0] eff_x1;
  logic [6:0] eff_y1;
  logic       cmd_bad;
  logic       cmd_empty;

`ifdef FB_RECT_CLIP_EN
  always_comb begin
    eff_x1    = ({1'b0, cmd_x1} >= X_LIM) ? X_MAX : cmd_x1;
    eff_y1    = ({1'b0, cmd_y1} >= Y_LIM) ? Y_MAX : cmd_y1;
    cmd_bad   = 1'b0;
    // An off-screen start cannot be clamped into anything meaningful.
    cmd_empty = ({1'b0, cmd_x0} >= X_LIM) || ({1'b0, cmd_y0} >= Y_LIM) ||
                (cmd_x0 > eff_x1) || (cmd_y0 > eff_y1);
  end
`else
  always_comb begin
    eff_x1    = cmd_x1;
    eff_y1    = cmd_y1;
    cmd_bad   = ({1'b0, cmd_x0} >= X_LIM) || ({1'b0, cmd_x1} >= X_LIM) ||
                ({1'b0, cmd_y0} >= Y_LIM) || ({1'b0, cmd_y1} >= Y_LIM);
    cmd_empty = (cmd_x0 > cmd_x1) || (cmd_y0 > cmd_y1);
  end
`endif

  // ---------------------------------------------------------------------------
  // Start address y0*H_RES + x0 without a multiplier: H_RES is a constant,
  // so only the set bits of the stride contribute a shifted copy of y0.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] pp [AW];
  logic [AW-1:0] start_addr;

  for (genvar gi = 0; gi < AW; gi++) begin : g_stride_pp
    if (ROW_STRIDE[gi]) begin : g_on
      assign pp[gi] = {{(AW-7){1'b0}}, cmd_y0} << gi;
    end else begin : g_off
      assign pp[gi] = '0;
    end
  end

  always_comb begin
    start_addr = {{(AW-8){1'b0}}, cmd_x0};
    for (int i = 0; i < AW; i++) begin
      start_addr = start_addr + pp[i];
    end
  end

  // ---------------------------------------------------------------------------
  // State register. Reset wins over everything, so a fill is aborted and a
  // command presented during reset is never taken.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_write) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      x_reg     <= '0;
      x0_reg    <= '0;
      x1_reg    <= '0;
      y_reg     <= '0;
      y1_reg    <= '0;
      addr_reg  <= '0;
      row_reg   <= '0;
      color_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      x0_reg    <= x0_next;
      x1_reg    <= x1_next;
      y_reg     <= y_next;
      y1_reg    <= y1_next;
      addr_reg  <= addr_next;
      row_reg   <= row_next;
      color_reg <= color_next;
      err_reg   <= err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. addr_reg always holds the address being written in the
  // current FILL cycle; it is only loaded from a validated start address, so
  // it never leaves the framebuffer.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    x0_next    = x0_reg;
    x1_next    = x1_reg;
    y_next     = y_reg;
    y1_next    = y1_reg;
    addr_next  = addr_reg;
    row_next   = row_reg;
    color_next = color_reg;
    err_next   = 1'b0;        // err is a pulse covering only the DONE cycle

    unique case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_bad || cmd_empty) begin
            state_next = ST_DONE;
            err_next   = cmd_bad;
          end else begin
            state_next = ST_FILL;
            x_next     = cmd_x0;
            x0_next    = cmd_x0;
            x1_next    = eff_x1;
            y_next     = cmd_y0;
            y1_next    = eff_y1;
            addr_next  = start_addr;
            row_next   = start_addr;
            color_next = cmd_color;
          end
        end
      end

      ST_FILL: begin
        if (x_reg == x1_reg) begin
          if (y_reg == y1_reg) begin
            state_next = ST_DONE;
          end else begin
            // Wrap to x0 on the next row: one stride below the row start.
            y_next    = y_reg + 7'd1;
            x_next    = x0_reg;
            addr_next = row_reg + ROW_STRIDE;
            row_next  = row_reg + ROW_STRIDE;
          end
        end else begin
          x_next    = x_reg + 8'd1;
          addr_next = addr_reg + {{(AW-1){1'b0}}, 1'b1};
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs, all decoded from registered state.
  // ---------------------------------------------------------------------------
  assign cmd_ready     = (state_reg == ST_IDLE);
  assign write_enable  = (state_reg == ST_FILL);
  assign write_address = addr_reg;
  assign data_out      = write_enable ? color_reg : 3'd0;
  assign busy          = (state_reg != ST_IDLE);
  assign done          = (state_reg == ST_DONE);
  assign err           = err_reg;

endmodule

// File: tb/tb_fb_rect_fill.sv
// -----------------------------------------------------------------------------
// tb_fb_rect_fill
//
// Self-checking bench for fb_rect_fill. A reference model expands every
// command into the list of addresses it must write. Each command is then
// checked for the address/data stream, gap-free timing, the done/err pulse and
// the handshake. A constant table pins down known corner cases. Two
// hand-written sequences cover back-to-back commands and reset during a fill.
// A batch of random commands follows. Honours FB_RECT_CLIP_EN like the design.
// -----------------------------------------------------------------------------
module tb_fb_rect_fill;

  localparam int H_RES = 160;
  localparam int V_RES = 120;

  logic        clk_write = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_x0;
  logic [6:0]  cmd_y0;
  logic [7:0]  cmd_x1;
  logic [6:0]  cmd_y1;
  logic [2:0]  cmd_color;
  logic        write_enable;
  logic [14:0] write_address;
  logic [2:0]  data_out;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk_write = ~clk_write;

  fb_rect_fill #(.H_RES(H_RES), .V_RES(V_RES)) dut (
    .clk_write     (clk_write),
    .resetn        (resetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_x0        (cmd_x0),
    .cmd_y0        (cmd_y0),
    .cmd_x1        (cmd_x1),
    .cmd_y1        (cmd_y1),
    .cmd_color     (cmd_color),
    .write_enable  (write_enable),
    .write_address (write_address),
    .data_out      (data_out),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model results for the command under test.
  int exp_addr_q[$];
  int exp_err;

  // Observations from the last run_cmd.
  int obs_count;
  int obs_first;
  int obs_last;
  int obs_err;

  typedef struct {
    int x0; int y0; int x1; int y1; int color;
    int n_writes; int first_addr; int last_addr; int err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Behavioural model: which pixels does a command cover, and is it rejected?
  task automatic model(input int x0, input int y0, input int x1, input int y1);
    int ex1;
    int ey1;
    exp_addr_q.delete();
    exp_err = 0;
    ex1 = x1;
    ey1 = y1;
`ifdef FB_RECT_CLIP_EN
    if (ex1 > H_RES - 1) ex1 = H_RES - 1;
    if (ey1 > V_RES - 1) ey1 = V_RES - 1;
    if (x0 >= H_RES || y0 >= V_RES) return;
`else
    if (x0 >= H_RES || x1 >= H_RES || y0 >= V_RES || y1 >= V_RES) begin
      exp_err = 1;
      return;
    end
`endif
    for (int y = y0; y <= ey1; y++)
      for (int x = x0; x <= ex1; x++)
        exp_addr_q.push_back(y * H_RES + x);
  endtask

  // Issue one command, follow it to completion and compare with the model.
  task automatic run_cmd(input int x0, input int y0, input int x1, input int y1, input int color);
    int got_addr[$];
    int cyc;
    int idx;
    int bad_idx;
    int wait_cyc;
    int done_cyc;
    bit hs_bad;
    bit done_seen;
    logic err_seen;

    model(x0, y0, x1, y1);
    @(negedge clk_write);
    cmd_x0    = 8'(x0);
    cmd_y0    = 7'(y0);
    cmd_x1    = 8'(x1);
    cmd_y1    = 7'(y1);
    cmd_color = 3'(color);
    cmd_valid = 1'b1;
    wait_cyc  = 0;
    while (cmd_ready !== 1'b1 && wait_cyc < 50) begin
      @(negedge clk_write);
      wait_cyc++;
    end
    check("accept_wait", 32'(wait_cyc < 50), 32'd1);
    if (wait_cyc >= 50) begin
      cmd_valid = 1'b0;
      return;
    end

    @(posedge clk_write);   // acceptance edge N
    #1;
    cmd_valid = 1'b0;
    // Fields are latched; scrambling them must not disturb the fill.
    cmd_x0    = 8'($urandom);
    cmd_y0    = 7'($urandom);
    cmd_x1    = 8'($urandom);
    cmd_y1    = 7'($urandom);
    cmd_color = 3'($urandom);

    cyc       = 0;
    bad_idx   = -1;
    hs_bad    = 1'b0;
    done_seen = 1'b0;
    done_cyc  = 0;
    err_seen  = 1'b0;
    while (!done_seen && cyc < exp_addr_q.size() + 10) begin
      @(negedge clk_write);
      cyc++;
      if (write_enable === 1'b1) begin
        idx = got_addr.size();
        if (bad_idx < 0 &&
            (idx >= exp_addr_q.size() || int'(write_address) != exp_addr_q[idx] ||
             data_out !== 3'(color) || cyc != idx + 1))
          bad_idx = idx;
        got_addr.push_back(int'(write_address));
      end else if (data_out !== 3'd0) begin
        hs_bad = 1'b1;
      end
      if (cmd_ready !== 1'b0 || busy !== 1'b1) hs_bad = 1'b1;
      if (done === 1'b1) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        err_seen  = err;
        if (write_enable !== 1'b0) hs_bad = 1'b1;
      end else if (err !== 1'b0) begin
        hs_bad = 1'b1;
      end
    end

    check("done_seen",   32'(done_seen), 32'd1);
    check("write_count", got_addr.size(), exp_addr_q.size());
    check("stream_bad_index", bad_idx, -1);
    check("done_cycle",  done_cyc, exp_addr_q.size() + 1);
    check("err_on_done", 32'(err_seen), exp_err);
    check("handshake",   32'(hs_bad), 32'd0);
    @(negedge clk_write);
    check("ready_after_done", 32'(cmd_ready), 32'd1);
    check("done_one_cycle",   32'(done), 32'd0);

    obs_count = got_addr.size();
    obs_first = (obs_count > 0) ? got_addr[0] : -1;
    obs_last  = (obs_count > 0) ? got_addr[obs_count-1] : -1;
    obs_err   = int'(err_seen);
    $display("[TB] cmd (%0d,%0d)-(%0d,%0d) color %0d: %0d writes, done at +%0d, err %0d",
             x0, y0, x1, y1, color, obs_count, done_cyc, obs_err);
  endtask

  // Global time bound so the run can never hang.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] we_bits;
    logic [9:0] done_bits;
    logic [9:0] rdy_bits;
    int         seq_addr[$];
    bit         quiet;
    int         x0, y0, x1, y1, color;

    // ------------------------------------------------------------- reset state
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_x0    = '0;
    cmd_y0    = '0;
    cmd_x1    = '0;
    cmd_y1    = '0;
    cmd_color = '0;
    repeat (3) @(negedge clk_write);
    check("rst_write_enable",  32'(write_enable),  32'd0);
    check("rst_write_address", 32'(write_address), 32'd0);
    check("rst_data_out",      32'(data_out),      32'd0);
    check("rst_busy",          32'(busy),          32'd0);
    check("rst_done",          32'(done),          32'd0);
    check("rst_err",           32'(err),           32'd0);
    check("rst_cmd_ready",     32'(cmd_ready),     32'd1);
    resetn = 1'b1;
    $display("[TB] reset state checked");

    // ------------------------------------------------------- table of vectors
    vecs.push_back('{0,   0,   1,   1,   5, 4,     0,     161,   0});
    vecs.push_back('{10,  0,   5,   3,   1, 0,     -1,    -1,    0});
    vecs.push_back('{5,   10,  5,   2,   3, 0,     -1,    -1,    0});
    vecs.push_back('{3,   3,   3,   3,   1, 1,     483,   483,   0});
    vecs.push_back('{159, 119, 159, 119, 4, 1,     19199, 19199, 0});
    vecs.push_back('{0,   5,   159, 5,   6, 160,   800,   959,   0});
`ifdef FB_RECT_CLIP_EN
    vecs.push_back('{150, 118, 200, 119, 2, 20,    19030, 19199, 0});
    vecs.push_back('{160, 0,   160, 0,   1, 0,     -1,    -1,    0});
`else
    vecs.push_back('{150, 118, 200, 119, 2, 0,     -1,    -1,    1});
    vecs.push_back('{160, 0,   160, 0,   1, 0,     -1,    -1,    1});
`endif
    vecs.push_back('{0,   0,   159, 119, 7, 19200, 0,     19199, 0});

    foreach (vecs[i]) begin
      run_cmd(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].color);
      check("tbl_count", obs_count, vecs[i].n_writes);
      check("tbl_err",   obs_err,   vecs[i].err);
      if (vecs[i].n_writes > 0) begin
        check("tbl_first_addr", obs_first, vecs[i].first_addr);
        check("tbl_last_addr",  obs_last,  vecs[i].last_addr);
      end
    end

    // ---------------------------- cmd_valid held high across two commands
    @(negedge clk_write);
    cmd_x0 = 8'd0; cmd_y0 = 7'd0; cmd_x1 = 8'd1; cmd_y1 = 7'd1; cmd_color = 3'd5;
    cmd_valid = 1'b1;
    @(posedge clk_write);
    #1;
    cmd_x0 = 8'd2; cmd_y0 = 7'd2; cmd_x1 = 8'd3; cmd_y1 = 7'd2; cmd_color = 3'd6;
    we_bits = '0; done_bits = '0; rdy_bits = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_write);
      we_bits[k-1]   = write_enable;
      done_bits[k-1] = done;
      rdy_bits[k-1]  = cmd_ready;
      if (write_enable === 1'b1) seq_addr.push_back(int'(write_address));
      if (k == 7) cmd_valid = 1'b0;
    end
    check("b2b_write_enable", 32'(we_bits),   32'h0CF);
    check("b2b_done",         32'(done_bits), 32'h110);
    check("b2b_cmd_ready",    32'(rdy_bits),  32'h220);
    check("b2b_write_count",  seq_addr.size(), 6);
    if (seq_addr.size() == 6) begin
      check("b2b_addr0", seq_addr[0], 0);
      check("b2b_addr1", seq_addr[1], 1);
      check("b2b_addr2", seq_addr[2], 160);
      check("b2b_addr3", seq_addr[3], 161);
      check("b2b_addr4", seq_addr[4], 322);
      check("b2b_addr5", seq_addr[5], 323);
    end
    $display("[TB] back-to-back commands with cmd_valid held: %0d writes", seq_addr.size());
    @(negedge clk_write);

    // ----------------------------------------------- reset during a fill
    cmd_x0 = 8'd0; cmd_y0 = 7'd0; cmd_x1 = 8'd159; cmd_y1 = 7'd119; cmd_color = 3'd7;
    cmd_valid = 1'b1;
    @(posedge clk_write);
    #1;
    cmd_valid = 1'b0;
    repeat (100) @(negedge clk_write);
    check("midfill_write_enable", 32'(write_enable),  32'd1);
    check("midfill_address",      32'(write_address), 32'd99);
    resetn = 1'b0;
    cmd_x0 = 8'd5; cmd_y0 = 7'd5; cmd_x1 = 8'd6; cmd_y1 = 7'd6; cmd_color = 3'd2;
    cmd_valid = 1'b1;               // must not be taken while in reset
    @(negedge clk_write);
    check("abort_write_enable",  32'(write_enable),  32'd0);
    check("abort_write_address", 32'(write_address), 32'd0);
    check("abort_data_out",      32'(data_out),      32'd0);
    check("abort_busy",          32'(busy),          32'd0);
    check("abort_done",          32'(done),          32'd0);
    check("abort_err",           32'(err),           32'd0);
    check("abort_cmd_ready",     32'(cmd_ready),     32'd1);
    resetn    = 1'b1;
    cmd_valid = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk_write);
      if (write_enable !== 1'b0 || done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    check("abort_quiet", 32'(quiet), 32'd1);
    $display("[TB] reset during full-screen fill: aborted, quiet %0d", quiet);
    run_cmd(3, 3, 3, 3, 1);
    check("post_reset_count", obs_count, 1);
    check("post_reset_addr",  obs_first, 483);

    // ------------------------------------------------- random commands
    for (int n = 0; n < 30; n++) begin
      x0 = int'($urandom_range(0, 165));
      x1 = x0 + int'($urandom_range(0, 12)) - 2;
      if (x1 < 0) x1 = 0;
      y0 = int'($urandom_range(0, 121));
      y1 = y0 + int'($urandom_range(0, 5)) - 1;
      if (y1 < 0) y1 = 0;
      color = int'($urandom_range(0, 7));
      run_cmd(x0, y0, x1, y1, color);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
